frame_capture: RTL and testbench
================================

# frame_capture

Synthesizable, parametrised pixel capture for the PPU video output. Samples `color` at each `ce` pixel tick inside the active raster, stores it in one of two frame banks, and on frame completion swaps banks so a complete frame can be read out through a registered read port while the next frame is captured. Sits beside the NES core, fed by its `color`, `cycle` and `scanline` outputs; replaces simulation-only frame dumping.

## Interface
- `H_ACTIVE`, 256, active pixels per line.
- `V_ACTIVE`, 240, active lines per frame.
- `PIX_W`, 6, input pixel width.
- `OUT_W`, 8, stored/read pixel width; must be ≥ `PIX_W`.
- `ADDR_W`, `$clog2(H_ACTIVE*V_ACTIVE)`, read address width.

- `clk` in 1: single clock.
- `reset` in 1: synchronous, active-high.
- `ce` in 1: pixel clock enable; capture logic advances only when high.
- `color` in `PIX_W`: pixel value.
- `cycle` in 9: horizontal position.
- `scanline` in 9: vertical position.
- `rd_en` in 1: read request.
- `rd_addr` in `ADDR_W`: linear address, `scanline*H_ACTIVE + cycle`.
- `rd_data` out `OUT_W`: read data.
- `rd_valid` out 1: `rd_data` is valid.
- `frame_ready` out 1: read bank holds a complete, unreleased frame.
- `frame_release` in 1: host is finished with the read bank.
- `frame_count` out 32: completed frames handed to the read bank (wraps).
- `drop_count` out 16: frames discarded because the read bank was held (saturates at 0xFFFF).
- `frame_crc` out 16: present only with `FRAME_CAPTURE_CRC_EN`.

## Operation
- Two banks of `H_ACTIVE*V_ACTIVE` × `OUT_W`. `wr_bank`/`rd_bank` are always complementary.
- Stored value: `{(OUT_W-PIX_W)'b0, color}`.
- FSM states:
  - `WAIT_SOF`: on `ce && scanline==0 && cycle==0`, write that pixel and move to `CAPTURE`.
  - `CAPTURE`: on `ce && scanline<V_ACTIVE && cycle<H_ACTIVE`, write the pixel to `wr_bank`. When writing (H_ACTIVE-1, V_ACTIVE-1), the frame is complete; return to `WAIT_SOF`.
- Frame completion:
  - If `frame_ready==0`, or `frame_release` is high in the same cycle: swap banks, set `frame_ready=1`, increment `frame_count`.
  - Otherwise: no swap, saturating increment of `drop_count`. The next frame overwrites `wr_bank`.
- `frame_release` with no completion in the same cycle clears `frame_ready`. Release while `frame_ready==0` has no effect.
- Reads always target `rd_bank` and are independent of `ce` and `frame_ready`.
  - `rd_addr ≥ H_ACTIVE*V_ACTIVE` returns 0.
  - Bank contents are not reset; reads before the first completion are undefined.
- Out-of-raster `ce` cycles (`cycle≥H_ACTIVE` or `scanline≥V_ACTIVE`) write nothing.

## Timing
- Reset values: state `WAIT_SOF`, `wr_bank=0`, `rd_bank=1`, `frame_ready=0`, `rd_valid=0`, `rd_data=0`, `frame_count=0`, `drop_count=0`, `frame_crc=0`.
- A pixel is written at the clk edge where `ce` is high.
- Completion:
  - `frame_ready` rises at the edge that writes the last pixel, so it is visible the following cycle.
  - `frame_count` updates at that same edge.
  - A read issued in the cycle after `frame_ready` rises returns the new frame.
- Read latency is 1: `rd_en` sampled at edge N gives `rd_data`/`rd_valid` after edge N. `rd_valid` is the registered `rd_en`. Back-to-back reads are allowed at one per clk.
- Reset mid-frame aborts the capture. Capture restarts only at the next (0,0).
- A swap coinciding with a read: the read sampled at the swap edge uses the pre-swap `rd_bank`.

## Configuration
- `FRAME_CAPTURE_CRC_EN` defined:
  - A running CRC-16-CCITT (poly 0x1021, init 0xFFFF, MSB-first, no reflection, no final XOR) is computed over each stored `OUT_W`-bit pixel in raster order.
  - It is reset to 0xFFFF on the (0,0) write.
  - `frame_crc` is latched from the final CRC at each swap and is unchanged on drops.
- Undefined: no CRC logic; the `frame_crc` port is absent.

## Test plan
- H=4, V=3, PIX_W=6, OUT_W=8: feed one frame with color = linear index (0..11) → `frame_ready=1` the cycle after pixel 11 and `frame_count=1`; reading addr 0..11 returns 0x00..0x0B with `rd_valid` 1 cycle after each `rd_en`; addr 12 returns 0.
- Hold `frame_ready` (no release) across 3 more frames → `drop_count=3`, `frame_count=1`, read data unchanged. Release, then one frame with color=0x3F → `frame_count=2`, all reads return 0x3F.
- Assert `frame_release` in the exact cycle of completion → swap occurs, `frame_ready` stays 1, `frame_count` increments, `drop_count` unchanged.
- Assert `reset` mid-frame (after pixel 5), then start stimulus at (2,1) → no writes until (0,0). Full frame completes with `frame_count=1`.
- Drive `ce` low for 2 of every 3 clks with a varying `color` → only `ce` cycles are captured. Pixels outside the raster (cycle=300, scanline=250) are ignored.
- `FRAME_CAPTURE_CRC_EN`, H=4, V=3: all-zero frame → `frame_crc` equals the reference-model CRC of twelve 0x00 bytes. Dropped frames leave `frame_crc` unchanged.

Source files
------------

// File: rtl/frame_capture.sv
// frame_capture: double-buffered PPU pixel capture with a registered read port.
// Pixels sampled on `ce` inside the active raster go to the write bank; when a
// frame completes and the host is not holding the read bank, the banks swap.
// Optional feature: define FRAME_CAPTURE_CRC_EN to add a CRC-16-CCITT of each
// handed-over frame on the `frame_crc` port.
module frame_capture #(
    parameter int H_ACTIVE = 256,
    parameter int V_ACTIVE = 240,
    parameter int PIX_W    = 6,
    parameter int OUT_W    = 8,
    parameter int ADDR_W   = $clog2(H_ACTIVE * V_ACTIVE)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ce,
    input  logic [PIX_W-1:0]  color,
    input  logic [8:0]        cycle,
    input  logic [8:0]        scanline,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [OUT_W-1:0]  rd_data,
    output logic              rd_valid,
    output logic              frame_ready,
    input  logic              frame_release,
    output logic [31:0]       frame_count,
    output logic [15:0]       drop_count
`ifdef FRAME_CAPTURE_CRC_EN
    ,
    output logic [15:0]       frame_crc
`endif
);

    localparam int         DEPTH  = H_ACTIVE * V_ACTIVE;
    localparam logic [8:0] H_LIM  = 9'(H_ACTIVE);
    localparam logic [8:0] V_LIM  = 9'(V_ACTIVE);
    localparam logic [8:0] H_LAST = 9'(H_ACTIVE - 1);
    localparam logic [8:0] V_LAST = 9'(V_ACTIVE - 1);

    typedef enum logic {
        WAIT_SOF = 1'b0,
        CAPTURE  = 1'b1
    } state_t;

    state_t state, state_next;

    logic [OUT_W-1:0] bank0 [DEPTH];
    logic [OUT_W-1:0] bank1 [DEPTH];

    logic              wr_bank;
    logic              rd_bank;
    logic              in_raster;
    logic              is_sof;
    logic              is_last;
    logic              wr_en;
    logic              frame_done;
    logic              swap;
    logic [ADDR_W-1:0] wr_addr;
    logic [OUT_W-1:0]  pix;
    logic              rd_in_range;

    // The two banks are always complementary; only the write bank is stored.
    assign rd_bank = ~wr_bank;

    // Raster position decode and write address / zero-extended pixel.
    always_comb begin
        in_raster   = (cycle < H_LIM) && (scanline < V_LIM);
        is_sof      = (cycle == 9'd0) && (scanline == 9'd0);
        is_last     = (cycle == H_LAST) && (scanline == V_LAST);
        wr_addr     = ADDR_W'(scanline) * ADDR_W'(H_ACTIVE) + ADDR_W'(cycle);
        pix         = OUT_W'(color);
        rd_in_range = {1'b0, rd_addr} < (ADDR_W + 1)'(DEPTH);
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) state <= WAIT_SOF;
        else       state <= state_next;
    end

    // FSM next-state: arm on the first pixel of a frame, disarm on the last.
    always_comb begin
        state_next = state;
        case (state)
            WAIT_SOF: if (ce && is_sof)  state_next = is_last ? WAIT_SOF : CAPTURE;
            CAPTURE:  if (ce && is_last) state_next = WAIT_SOF;
            default:  state_next = WAIT_SOF;
        endcase
    end

    // FSM outputs: pixel write strobe and frame-complete pulse.
    always_comb begin
        wr_en      = 1'b0;
        frame_done = 1'b0;
        case (state)
            WAIT_SOF: wr_en = ce && is_sof;
            CAPTURE:  wr_en = ce && in_raster;
            default:  wr_en = 1'b0;
        endcase
        frame_done = wr_en && is_last;
        // Hand over only if the read bank is free or being freed right now.
        swap       = frame_done && (!frame_ready || frame_release);
    end

    // Pixel storage into the write bank (contents are never reset).
    always_ff @(posedge clk) begin
        if (wr_en) begin
            if (wr_bank) bank1[wr_addr] <= pix;
            else         bank0[wr_addr] <= pix;
        end
    end

    // Registered read port; uses the bank selection in effect before any swap at this edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                if (!rd_in_range) rd_data <= '0;
                else if (rd_bank) rd_data <= bank1[rd_addr];
                else              rd_data <= bank0[rd_addr];
            end
        end
    end

    // Bank swap, frame handshake and frame/drop counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_bank     <= 1'b0;
            frame_ready <= 1'b0;
            frame_count <= '0;
            drop_count  <= '0;
        end else if (frame_done) begin
            if (swap) begin
                wr_bank     <= ~wr_bank;
                frame_ready <= 1'b1;
                frame_count <= frame_count + 32'd1;
            end else if (drop_count != 16'hFFFF) begin
                drop_count  <= drop_count + 16'd1;
            end
        end else if (frame_release) begin
            frame_ready <= 1'b0;
        end
    end

`ifdef FRAME_CAPTURE_CRC_EN
    // CRC-16-CCITT, poly 0x1021, MSB first, over one stored pixel.
    function automatic logic [15:0] crc_step(input logic [15:0] crc_in,
                                             input logic [OUT_W-1:0] d);
        logic [15:0] c;
        logic        fb;
        c = crc_in;
        for (int i = OUT_W - 1; i >= 0; i--) begin
            fb = c[15] ^ d[i];
            c  = {c[14:0], 1'b0};
            if (fb) c = c ^ 16'h1021;
        end
        return c;
    endfunction

    logic [15:0] crc_run;
    logic [15:0] crc_next;

    // Running CRC including the pixel being written; restarts at (0,0).
    always_comb begin
        crc_next = crc_step(is_sof ? 16'hFFFF : crc_run, pix);
    end

    // Running CRC register and the value latched at each hand-over.
    always_ff @(posedge clk) begin
        if (reset) begin
            crc_run   <= 16'hFFFF;
            frame_crc <= '0;
        end else begin
            if (wr_en) crc_run   <= crc_next;
            if (swap)  frame_crc <= crc_next;
        end
    end
`endif

endmodule

// File: tb/tb_frame_capture.sv
// Randomised self-checking bench for frame_capture at H=4, V=3. A frame-level
// reference model tracks the frame being assembled, the frame handed to the
// reader, and the handshake counters. Define FRAME_CAPTURE_CRC_EN to also
// cover the CRC output.
module tb_frame_capture;

    localparam int H  = 4;
    localparam int V  = 3;
    localparam int N  = H * V;
    localparam int PW = 6;
    localparam int OW = 8;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          ce;
    logic [PW-1:0] color;
    logic [8:0]    cycle;
    logic [8:0]    scanline;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [OW-1:0] rd_data;
    logic          rd_valid;
    logic          frame_ready;
    logic          frame_release;
    logic [31:0]   frame_count;
    logic [15:0]   drop_count;
`ifdef FRAME_CAPTURE_CRC_EN
    logic [15:0]   frame_crc;
`endif

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    bit          m_cap;
    int          m_wr [N];
    int          m_rd [N];
    bit          m_ready;
    int unsigned m_count;
    int          m_drop;
`ifdef FRAME_CAPTURE_CRC_EN
    logic [15:0] m_crc;
`endif

    always #5 clk = ~clk;

    frame_capture #(
        .H_ACTIVE(H), .V_ACTIVE(V), .PIX_W(PW), .OUT_W(OW), .ADDR_W(AW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .ce           (ce),
        .color        (color),
        .cycle        (cycle),
        .scanline     (scanline),
        .rd_en        (rd_en),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .frame_ready  (frame_ready),
        .frame_release(frame_release),
        .frame_count  (frame_count),
        .drop_count   (drop_count)
`ifdef FRAME_CAPTURE_CRC_EN
        ,
        .frame_crc    (frame_crc)
`endif
    );

`ifdef FRAME_CAPTURE_CRC_EN
    // CRC-16-CCITT of a whole frame in raster order.
    function automatic logic [15:0] ref_crc();
        logic [15:0] c;
        logic [7:0]  b;
        c = 16'hFFFF;
        for (int p = 0; p < N; p++) begin
            b = 8'(m_wr[p]);
            for (int k = 7; k >= 0; k--) begin
                if (c[15] ^ b[k]) c = {c[14:0], 1'b0} ^ 16'h1021;
                else              c = {c[14:0], 1'b0};
            end
        end
        return c;
    endfunction
`endif

    // Frame-level behaviour for one clock with the given inputs.
    function automatic void model_step(input bit r, input bit e, input int c,
                                       input int s, input int col, input bit rel);
        bit done;
        done = 1'b0;
        if (r) begin
            m_cap = 0; m_ready = 0; m_count = 0; m_drop = 0;
`ifdef FRAME_CAPTURE_CRC_EN
            m_crc = 16'h0000;
`endif
            return;
        end
        if (e && c < H && s < V) begin
            if (c == 0 && s == 0) m_cap = 1;
            if (m_cap) begin
                m_wr[s * H + c] = col;
                if (c == H - 1 && s == V - 1) begin
                    done  = 1'b1;
                    m_cap = 0;
                end
            end
        end
        if (done) begin
            if (!m_ready || rel) begin
                m_rd    = m_wr;
                m_ready = 1;
                m_count++;
`ifdef FRAME_CAPTURE_CRC_EN
                m_crc   = ref_crc();
`endif
            end else if (m_drop < 65535) begin
                m_drop++;
            end
        end else if (rel) begin
            m_ready = 0;
        end
    endfunction

    task automatic cyc(input bit r, input bit e, input int c, input int s,
                       input int col, input bit rel);
        model_step(r, e, c, s, col, rel);
        reset         = r;
        ce            = e;
        cycle         = 9'(c);
        scanline      = 9'(s);
        color         = PW'(col);
        frame_release = rel;
        @(posedge clk); #1;
    endtask

    // mode 0: linear index, 1: all 0x3F, 2: random, 3: all zero
    task automatic feed_frame(input int mode, input bit rel_last);
        int col;
        for (int i = 0; i < N; i++) begin
            case (mode)
                0:       col = i;
                1:       col = 63;
                2:       col = int'($urandom_range(0, 63));
                default: col = 0;
            endcase
            cyc(0, 1, i % H, i / H, col, rel_last && (i == N - 1));
        end
        cyc(0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_reset();
        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        n_checks++;
        if (frame_ready !== 1'b0) begin
            $display("FAIL reset_frame_ready got=%b want=0", frame_ready); n_errors++;
        end
        n_checks++;
        if (rd_valid !== 1'b0 || rd_data !== 8'h00) begin
            $display("FAIL reset_read got valid=%b data=%h want valid=0 data=00", rd_valid, rd_data); n_errors++;
        end
        n_checks++;
        if (frame_count !== 32'd0 || drop_count !== 16'd0) begin
            $display("FAIL reset_counts got fc=%0d dc=%0d want 0 0", frame_count, drop_count); n_errors++;
        end
`ifdef FRAME_CAPTURE_CRC_EN
        n_checks++;
        if (frame_crc !== 16'h0000) begin
            $display("FAIL reset_crc got=%h want=0000", frame_crc); n_errors++;
        end
`endif
    endtask

    task automatic test_basic_frame();
        int exp;
        for (int i = 0; i < N; i++) begin
            cyc(0, 1, i % H, i / H, i, 0);
            if (i == N - 2) begin
                n_checks++;
                if (frame_ready !== 1'b0) begin
                    $display("FAIL basic_ready_early got=%b want=0", frame_ready); n_errors++;
                end
            end
        end
        n_checks++;
        if (frame_ready !== 1'b1 || frame_count !== 32'(m_count) || m_count != 1) begin
            $display("FAIL basic_complete got ready=%b fc=%0d want ready=1 fc=%0d", frame_ready, frame_count, m_count); n_errors++;
        end
        ce = 1'b0; frame_release = 1'b0;
        for (int a = 0; a <= N; a++) begin
            rd_en = 1'b1; rd_addr = AW'(a);
            @(posedge clk); #1;
            exp = (a < N) ? m_rd[a] : 0;
            n_checks++;
            if (rd_valid !== 1'b1 || rd_data !== 8'(exp)) begin
                $display("FAIL basic_read addr=%0d got valid=%b data=%h want valid=1 data=%h", a, rd_valid, rd_data, 8'(exp)); n_errors++;
            end
        end
        rd_en = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (rd_valid !== 1'b0) begin
            $display("FAIL basic_valid_drop got=%b want=0", rd_valid); n_errors++;
        end
    endtask

    task automatic test_drops();
        for (int f = 0; f < 3; f++) feed_frame(2, 0);
        n_checks++;
        if (drop_count !== 16'(m_drop) || frame_count !== 32'(m_count) || frame_ready !== 1'b1) begin
            $display("FAIL drops_counts got dc=%0d fc=%0d ready=%b want dc=%0d fc=%0d ready=1", drop_count, frame_count, frame_ready, m_drop, m_count); n_errors++;
        end
`ifdef FRAME_CAPTURE_CRC_EN
        n_checks++;
        if (frame_crc !== m_crc) begin
            $display("FAIL drops_crc got=%h want=%h", frame_crc, m_crc); n_errors++;
        end
`endif
        ce = 1'b0;
        for (int a = 0; a < N; a++) begin
            rd_en = 1'b1; rd_addr = AW'(a);
            @(posedge clk); #1;
            n_checks++;
            if (rd_data !== 8'(m_rd[a])) begin
                $display("FAIL drops_read addr=%0d got=%h want=%h", a, rd_data, 8'(m_rd[a])); n_errors++;
            end
        end
        rd_en = 1'b0;
        cyc(0, 0, 0, 0, 0, 1);
        n_checks++;
        if (frame_ready !== 1'b0) begin
            $display("FAIL release_clears got=%b want=0", frame_ready); n_errors++;
        end
        cyc(0, 0, 0, 0, 0, 1);
        feed_frame(1, 0);
        n_checks++;
        if (frame_count !== 32'(m_count) || frame_ready !== 1'b1 || drop_count !== 16'(m_drop)) begin
            $display("FAIL refill_counts got fc=%0d ready=%b dc=%0d want fc=%0d ready=1 dc=%0d", frame_count, frame_ready, drop_count, m_count, m_drop); n_errors++;
        end
        for (int a = 0; a < N; a++) begin
            rd_en = 1'b1; rd_addr = AW'(a);
            @(posedge clk); #1;
            n_checks++;
            if (rd_data !== 8'(m_rd[a]) || rd_data !== 8'h3F) begin
                $display("FAIL refill_read addr=%0d got=%h want=%h", a, rd_data, 8'(m_rd[a])); n_errors++;
            end
        end
        rd_en = 1'b0;
    endtask

    task automatic test_release_at_completion();
        feed_frame(2, 1);
        n_checks++;
        if (frame_ready !== 1'b1 || frame_count !== 32'(m_count) || drop_count !== 16'(m_drop)) begin
            $display("FAIL rel_at_done got ready=%b fc=%0d dc=%0d want ready=1 fc=%0d dc=%0d", frame_ready, frame_count, drop_count, m_count, m_drop); n_errors++;
        end
        for (int a = 0; a < N; a++) begin
            rd_en = 1'b1; rd_addr = AW'(a);
            @(posedge clk); #1;
            n_checks++;
            if (rd_data !== 8'(m_rd[a])) begin
                $display("FAIL rel_at_done_read addr=%0d got=%h want=%h", a, rd_data, 8'(m_rd[a])); n_errors++;
            end
        end
        rd_en = 1'b0;
`ifdef FRAME_CAPTURE_CRC_EN
        n_checks++;
        if (frame_crc !== m_crc) begin
            $display("FAIL rel_at_done_crc got=%h want=%h", frame_crc, m_crc); n_errors++;
        end
`endif
    endtask

    task automatic test_reset_midframe();
        cyc(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) cyc(0, 1, i % H, i / H, int'($urandom_range(0, 63)), 0);
        cyc(1, 0, 0, 0, 0, 0);
        for (int i = 6; i < N; i++) cyc(0, 1, i % H, i / H, int'($urandom_range(0, 63)), 0);
        cyc(0, 0, 0, 0, 0, 0);
        n_checks++;
        if (frame_ready !== 1'b0 || frame_count !== 32'd0) begin
            $display("FAIL midreset_no_frame got ready=%b fc=%0d want ready=0 fc=0", frame_ready, frame_count); n_errors++;
        end
        feed_frame(2, 0);
        n_checks++;
        if (frame_ready !== 1'b1 || frame_count !== 32'(m_count) || m_count != 1) begin
            $display("FAIL midreset_frame got ready=%b fc=%0d want ready=1 fc=%0d", frame_ready, frame_count, m_count); n_errors++;
        end
        for (int a = 0; a < N; a++) begin
            rd_en = 1'b1; rd_addr = AW'(a);
            @(posedge clk); #1;
            n_checks++;
            if (rd_data !== 8'(m_rd[a])) begin
                $display("FAIL midreset_read addr=%0d got=%h want=%h", a, rd_data, 8'(m_rd[a])); n_errors++;
            end
        end
        rd_en = 1'b0;
    endtask

    task automatic test_ce_gating();
        cyc(0, 0, 0, 0, 0, 1);
        for (int i = 0; i < N; i++) begin
            for (int g = 0; g < 2; g++)
                cyc(0, 0, int'($urandom_range(0, H - 1)), int'($urandom_range(0, V - 1)),
                    int'($urandom_range(0, 63)), 0);
            if (i == 5) begin
                cyc(0, 1, 300, 250, int'($urandom_range(0, 63)), 0);
                cyc(0, 1, 300, 1,   int'($urandom_range(0, 63)), 0);
                cyc(0, 1, 1,   250, int'($urandom_range(0, 63)), 0);
            end
            cyc(0, 1, i % H, i / H, int'($urandom_range(0, 63)), 0);
        end
        cyc(0, 0, 0, 0, 0, 0);
        n_checks++;
        if (frame_ready !== 1'b1 || frame_count !== 32'(m_count)) begin
            $display("FAIL gating_complete got ready=%b fc=%0d want ready=1 fc=%0d", frame_ready, frame_count, m_count); n_errors++;
        end
        for (int a = 0; a < N; a++) begin
            rd_en = 1'b1; rd_addr = AW'(a);
            @(posedge clk); #1;
            n_checks++;
            if (rd_data !== 8'(m_rd[a])) begin
                $display("FAIL gating_read addr=%0d got=%h want=%h", a, rd_data, 8'(m_rd[a])); n_errors++;
            end
        end
        rd_en = 1'b0;
    endtask

`ifdef FRAME_CAPTURE_CRC_EN
    task automatic test_crc();
        cyc(0, 0, 0, 0, 0, 1);
        feed_frame(3, 0);
        n_checks++;
        if (frame_crc !== m_crc) begin
            $display("FAIL crc_zero_frame got=%h want=%h", frame_crc, m_crc); n_errors++;
        end
        feed_frame(2, 0);
        feed_frame(2, 0);
        n_checks++;
        if (frame_crc !== m_crc || drop_count !== 16'(m_drop)) begin
            $display("FAIL crc_after_drops got crc=%h dc=%0d want crc=%h dc=%0d", frame_crc, drop_count, m_crc, m_drop); n_errors++;
        end
    endtask
`endif

    initial begin
        reset = 1'b1; ce = 1'b0; color = '0; cycle = '0; scanline = '0;
        rd_en = 1'b0; rd_addr = '0; frame_release = 1'b0;
        test_reset();
        test_basic_frame();
        test_drops();
        test_release_at_completion();
        test_reset_midframe();
        test_ce_gating();
`ifdef FRAME_CAPTURE_CRC_EN
        test_crc();
`endif
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
